// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, default widths and the
// reset vector.
package cpu_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   localparam logic [31:0] RESET_VEC = 32'h0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_REQ   = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_FAULT = 3'd5
   } fetch_state_t;

   // Instruction fetches are word aligned; any low address bit set is a fault.
   function automatic logic misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: latches the PC, fetches from variable-latency
// memory over req/ack and hands the word to decode over valid/ready.
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic              pc_en,
   input  logic              redirect,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              core_ready,
   output logic              fault
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mem_addr_q <= ADDR_W'(RESET_VEC);
         inst_q     <= '0;
         inst_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
      end
   end

   // pc_en is only raised where the PC may change; pc_addr is therefore
   // stable whenever ISSUE samples it.
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      pc_en      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            pc_en   = redirect;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (redirect) begin
               pc_en = 1'b1;
            end else if (misaligned(pc_addr[1:0])) begin
               state_d = ST_FAULT;
            end else begin
               mem_addr_d = pc_addr;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (redirect) begin
               pc_en   = 1'b1;
               state_d = mem_ack ? ST_ISSUE : ST_DRAIN;
            end else if (mem_ack) begin
               inst_d    = mem_rdata;
               inst_pc_d = mem_addr_q;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect || core_ready) begin
               pc_en   = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            // The request cannot be withdrawn, so wait out the ack and drop it.
            pc_en = redirect;
            if (mem_ack) state_d = ST_ISSUE;
         end
         ST_FAULT: begin
            if (redirect) begin
               pc_en   = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_req    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
   assign mem_addr   = mem_addr_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = (state_q == ST_HOLD);
   assign fault      = (state_q == ST_FAULT);

endmodule
